uii2c_slave: RTL and testbench

- I2C target (slave) counterpart to the codebase's I2C master.
- Lets the FPGA be addressed over I2C by an external or on-chip master, e.g. for loopback tests of master-driven sensor configuration or for exposing control registers.
- Oversamples SCL/SDA on the system clock, decodes START/STOP, matches a 7-bit device address, keeps an 8-bit register pointer and drives a simple single-cycle register read/write port.

---
 rtl/uii2c_slave.sv | 234 +++++++++++++++++++++++
 tb/tb_uii2c_slave.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uii2c_slave.sv
// I2C target with 7-bit address match, auto-incrementing 8-bit register pointer and single-cycle reg port.
// SCL is never stretched; `define UII2C_SLAVE_GCALL_EN to ACK and discard general-call (8'h00) writes.
module uii2c_slave #(
  parameter logic [6:0]  DEV_ADDR = 7'h3C,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       iic_scl,
  inout  wire        iic_sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       iic_busy,
  output logic       iic_sda_dg
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  // Bit 1 = SCL, bit 0 = SDA through synchroniser and glitch filter.
  logic [1:0] raw, sync1, sync2, filt, filt_q;
  logic [3:0] fcnt [2];

  assign raw = {iic_scl, iic_sda};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      filt_q  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (fcnt[i] == 4'(FILT_LEN - 1)) begin
            filt[i] <= sync2[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 4'd1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = filt[1];
  assign sda_f     = filt[0];
  assign scl_rise  = filt[1] & ~filt_q[1];
  assign scl_fall  = ~filt[1] & filt_q[1];
  assign start_det = scl_f & filt_q[1] & filt_q[0] & ~sda_f;
  assign stop_det  = scl_f & filt_q[1] & ~filt_q[0] & sda_f;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] rx, rx_n, tx, tx_n, ptr, ptr_n, wdata_n;
  logic [7:0] rx_byte;
  logic       sda_oe, oe_n, busy_n, done, done_n, rw, rw_n, gc, gc_n;
  logic       wr_n, rd_n, rd_cap, cap_n, gc_hit;

  assign rx_byte = {rx[6:0], sda_f};

`ifdef UII2C_SLAVE_GCALL_EN
  assign gc_hit = (rx_byte == 8'h00);
`else
  assign gc_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= 3'd7;
      rx        <= '0;
      tx        <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      iic_busy  <= 1'b0;
      done      <= 1'b0;
      rw        <= 1'b0;
      gc        <= 1'b0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_wdata <= '0;
      rd_cap    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rx        <= rx_n;
      tx        <= tx_n;
      ptr       <= ptr_n;
      sda_oe    <= oe_n;
      iic_busy  <= busy_n;
      done      <= done_n;
      rw        <= rw_n;
      gc        <= gc_n;
      reg_wr    <= wr_n;
      reg_rd    <= rd_n;
      reg_wdata <= wdata_n;
      rd_cap    <= cap_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rx_n    = rx;
    tx_n    = tx;
    ptr_n   = ptr;
    oe_n    = sda_oe;
    busy_n  = iic_busy;
    done_n  = done;
    rw_n    = rw;
    gc_n    = gc;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    wdata_n = reg_wdata;
    cap_n   = reg_rd;
    // Read data arrives the cycle after reg_rd; pointer advances the cycle after reg_wr.
    if (rd_cap) tx_n = reg_rdata;
    if (reg_wr) ptr_n = ptr + 8'd1;

    if (start_det) begin
      state_n = ADDR;
      cnt_n   = 3'd7;
      oe_n    = 1'b0;
      done_n  = 1'b0;
      gc_n    = 1'b0;
    end else if (stop_det) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise && !done) begin
            rx_n = rx_byte;
            if (cnt != 3'd0) begin
              cnt_n = cnt - 3'd1;
            end else if (state == PTR) begin
              ptr_n  = rx_byte;
              done_n = 1'b1;
            end else if (state == WDATA) begin
              done_n = 1'b1;
              if (!gc) begin
                wr_n    = 1'b1;
                wdata_n = rx_byte;
              end
            end else if (rx_byte[7:1] == DEV_ADDR) begin
              done_n = 1'b1;
              rw_n   = rx_byte[0];
              rd_n   = rx_byte[0];
            end else if (gc_hit) begin
              done_n = 1'b1;
              rw_n   = 1'b0;
              gc_n   = 1'b1;
            end else begin
              state_n = WAIT_STOP;
              busy_n  = 1'b0;
            end
          end else if (scl_fall && done) begin
            done_n = 1'b0;
            oe_n   = 1'b1;
            case (state)
              ADDR: begin
                state_n = ADDR_ACK;
                busy_n  = 1'b1;
              end
              PTR:     state_n = PTR_ACK;
              default: state_n = WDATA_ACK;
            endcase
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            cnt_n = 3'd7;
            if (state == ADDR_ACK && rw) begin
              state_n = RDATA;
              oe_n    = ~tx[7];
            end else begin
              state_n = (state == ADDR_ACK && !gc) ? PTR : WDATA;
              oe_n    = 1'b0;
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt == 3'd0) begin
              state_n = RDATA_ACK;
              oe_n    = 1'b0;
            end else begin
              cnt_n = cnt - 3'd1;
              tx_n  = {tx[6:0], 1'b0};
              oe_n  = ~tx[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              ptr_n  = ptr + 8'd1;
              rd_n   = 1'b1;
              done_n = 1'b1;
            end else begin
              state_n = WAIT_STOP;
            end
          end else if (scl_fall && done) begin
            done_n  = 1'b0;
            cnt_n   = 3'd7;
            oe_n    = ~tx[7];
            state_n = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign iic_sda    = sda_oe ? 1'b0 : 1'bz;
  assign reg_addr   = ptr;
  assign iic_sda_dg = sda_f;

endmodule

// File: tb/tb_uii2c_slave.sv
// Bench for uii2c_slave: bit-banged I2C master, strobe scoreboard, addr+1 register read model.
module tb_uii2c_slave;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       scl = 1'b1;
  logic       mst_low = 1'b0;
  logic [7:0] reg_rdata = 8'h00;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_wr, reg_rd, iic_busy, iic_sda_dg;
  wire        sda;

  pullup (sda);
  assign sda = mst_low ? 1'b0 : 1'bz;

  always #5 clk_i = ~clk_i;

  uii2c_slave dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .iic_scl    (scl),
    .iic_sda    (sda),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_rdata  (reg_rdata),
    .iic_busy   (iic_busy),
    .iic_sda_dg (iic_sda_dg)
  );

`ifdef UII2C_SLAVE_GCALL_EN
  localparam logic GC_ACK = 1'b0;
`else
  localparam logic GC_ACK = 1'b1;
`endif

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } strobe_t;

  strobe_t exp_q[$];
  int passed = 0;
  int total  = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Register file model: returns addr+1, valid the cycle after reg_rd.
  always @(posedge clk_i) if (reg_rd) reg_rdata <= reg_addr + 8'd1;

  always @(negedge clk_i) begin
    strobe_t e;
    if (!rst_i && (reg_wr || reg_rd)) begin
      check("wr_rd_exclusive", {7'b0, reg_wr & reg_rd}, 8'h00);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 8'(exp_q.size()), 8'd1);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {7'b0, reg_wr}, {7'b0, e.wr});
        check("strobe_addr", reg_addr, e.addr);
        if (e.wr) check("strobe_wdata", reg_wdata, e.data);
      end
    end
  end

  task automatic wt(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic i2c_start();
    mst_low = 1'b0; wt(10);
    scl = 1'b1;     wt(20);
    mst_low = 1'b1; wt(20);
    scl = 1'b0;     wt(10);
  endtask

  task automatic i2c_stop();
    mst_low = 1'b1; wt(10);
    scl = 1'b1;     wt(20);
    mst_low = 1'b0; wt(20);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    mst_low = ~b; wt(10);
    scl = 1'b1;   wt(15);
    s = sda;      wt(5);
    scl = 1'b0;   wt(10);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(mack, s);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;

    // Reset state
    wt(3);
    check("rst_sda", {7'b0, sda}, 8'h01);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_reg_wr", {7'b0, reg_wr}, 8'h00);
    check("rst_reg_rd", {7'b0, reg_rd}, 8'h00);
    check("rst_busy", {7'b0, iic_busy}, 8'h00);
    check("rst_sda_dg", {7'b0, iic_sda_dg}, 8'h01);
    rst_i = 1'b0;
    wt(10);

    // Burst write
    i2c_start();
    wr_byte(8'h78, ack); check("wr_addr_ack", {7'b0, ack}, 8'h00);
    check("wr_busy", {7'b0, iic_busy}, 8'h01);
    wr_byte(8'h10, ack); check("wr_ptr_ack", {7'b0, ack}, 8'h00);
    exp_q.push_back('{1'b1, 8'h10, 8'hAA});
    wr_byte(8'hAA, ack); check("wr_d0_ack", {7'b0, ack}, 8'h00);
    exp_q.push_back('{1'b1, 8'h11, 8'h55});
    wr_byte(8'h55, ack); check("wr_d1_ack", {7'b0, ack}, 8'h00);
    i2c_stop();
    check("wr_busy_after_stop", {7'b0, iic_busy}, 8'h00);
    check("wr_ptr_end", reg_addr, 8'h12);

    // Random read with repeated START
    i2c_start();
    wr_byte(8'h78, ack); check("rd_addrw_ack", {7'b0, ack}, 8'h00);
    wr_byte(8'h20, ack); check("rd_ptr_ack", {7'b0, ack}, 8'h00);
    exp_q.push_back('{1'b0, 8'h20, 8'h00});
    i2c_start();
    wr_byte(8'h79, ack); check("rd_addrr_ack", {7'b0, ack}, 8'h00);
    exp_q.push_back('{1'b0, 8'h21, 8'h00});
    rd_byte(1'b0, d); check("rd_byte0", d, 8'h21);
    rd_byte(1'b1, d); check("rd_byte1", d, 8'h22);
    wt(3);
    check("rd_sda_released", {7'b0, sda}, 8'h01);
    i2c_stop();
    check("rd_ptr_end", reg_addr, 8'h21);

    // Wrong address, then a valid one
    i2c_start();
    wr_byte(8'h7A, ack); check("bad_addr_nack", {7'b0, ack}, 8'h01);
    check("bad_addr_busy", {7'b0, iic_busy}, 8'h00);
    i2c_start();
    wr_byte(8'h78, ack); check("after_bad_ack", {7'b0, ack}, 8'h00);
    i2c_stop();
    check("bad_ptr_kept", reg_addr, 8'h21);

    // Pointer wrap
    i2c_start();
    wr_byte(8'h78, ack);
    wr_byte(8'hFF, ack);
    exp_q.push_back('{1'b1, 8'hFF, 8'h01});
    wr_byte(8'h01, ack); check("wrap_d0_ack", {7'b0, ack}, 8'h00);
    exp_q.push_back('{1'b1, 8'h00, 8'h02});
    wr_byte(8'h02, ack); check("wrap_d1_ack", {7'b0, ack}, 8'h00);
    i2c_stop();
    check("wrap_ptr_end", reg_addr, 8'h01);

    // One-cycle SDA glitch while SCL high must not start a transfer
    wt(10);
    mst_low = 1'b1; wt(1);
    mst_low = 1'b0; wt(20);
    check("glitch_sda_dg", {7'b0, iic_sda_dg}, 8'h01);
    scl = 1'b0; wt(10);
    wr_byte(8'h78, ack); check("glitch_no_start", {7'b0, ack}, 8'h01);
    i2c_stop();

    // Reset while driving a read data bit low
    i2c_start();
    wr_byte(8'h78, ack);
    wr_byte(8'h00, ack);
    exp_q.push_back('{1'b0, 8'h00, 8'h00});
    i2c_start();
    wr_byte(8'h79, ack); check("rst_rd_ack", {7'b0, ack}, 8'h00);
    wt(5);
    check("rdata_sda_driven", {7'b0, sda}, 8'h00);
    rst_i = 1'b1;
    #1;
    check("rst_async_sda", {7'b0, sda}, 8'h01);
    check("rst_mid_busy", {7'b0, iic_busy}, 8'h00);
    wt(3);
    rst_i = 1'b0;
    wt(10);
    i2c_stop();
    check("rst_mid_ptr", reg_addr, 8'h00);

    // General call
    i2c_start();
    wr_byte(8'h00, ack); check("gcall_addr_ack", {7'b0, ack}, {7'b0, GC_ACK});
    wr_byte(8'h06, ack); check("gcall_data_ack", {7'b0, ack}, {7'b0, GC_ACK});
    check("gcall_busy", {7'b0, iic_busy}, {7'b0, ~GC_ACK});
    i2c_stop();
    check("gcall_ptr", reg_addr, 8'h00);

    wt(20);
    check("strobes_all_seen", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
